uart_fifo_tx: RTL and testbench

UART_FIFO_TX -- requirements
Module: uart_fifo_tx

---
 rtl/uart_pkg.sv | 15 +
 rtl/baud_tick.sv | 31 +++
 rtl/uart_fifo_tx.sv | 126 ++++++++++++
 tb/tb_uart_fifo_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM encoding and frame geometry.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned FrameBits = 10;
  localparam int unsigned DataBits  = FrameBits - 2;

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned CNT_W        = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_fifo_tx.sv
// 8N1 UART transmitter that pops bytes straight from an upstream FIFO, one per frame.
module uart_fifo_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10416,
  parameter int unsigned CNT_W        = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] dataIn,
  input  logic       isEmpty,
  output logic       re,
  output logic       tx,
  output logic       isBusy,
  output logic       frameDone
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;
  logic       armed_q, armed_d;
  tx_state_e  state_q, state_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       done_q, done_d;
  logic       clear;
  logic       tick;

  // Assert asynchronously, release two edges after the external reset lets go.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_int = rst_sync_q[1];

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud_tick (
    .clk  (clk),
    .reset(rst_n_int),
    .clear(clear),
    .tick (tick)
  );

  always_comb begin
    armed_d = 1'b1;
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    re      = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        // armed_q keeps re low while reset is held and for the first cycles after release.
        if (armed_q && en && !isEmpty) begin
          re      = 1'b1;
          shift_d = dataIn;
          state_d = StStart;
          tx_d    = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (tick) begin
          if (bit_q == 3'(DataBits - 1)) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
    endcase
    clear = (state_q == StIdle) || (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      armed_q <= 1'b0;
      state_q <= StIdle;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      armed_q <= armed_d;
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx        = tx_q;
  assign isBusy    = (state_q != StIdle);
  assign frameDone = done_q;

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx at 4 clocks per bit, fed from a queue acting as the FIFO.
module tb_uart_fifo_tx;

  localparam int unsigned Cpb  = 4;
  localparam int unsigned CntW = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] data_in;
  logic       is_empty;
  logic       re, tx, is_busy, frame_done;

  logic [7:0] fifo[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         r0, r1, r2;
  logic       re_s, tx_s, busy_s, done_s;

  uart_fifo_tx #(
    .CLKS_PER_BIT(Cpb),
    .CNT_W       (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dataIn   (data_in),
    .isEmpty  (is_empty),
    .re       (re),
    .tx       (tx),
    .isBusy   (is_busy),
    .frameDone(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    is_empty = (fifo.size() == 0);
    data_in  = is_empty ? 8'h00 : fifo[0];
  endtask

  // Sample one cycle at its falling edge, then pop the model FIFO if re was seen.
  task automatic step();
    @(negedge clk);
    cyc++;
    re_s   = re;
    tx_s   = tx;
    busy_s = is_busy;
    done_s = frame_done;
    @(posedge clk);
    #1;
    if (re_s && fifo.size() > 0) begin
      void'(fifo.pop_front());
    end
    drive_fifo();
  endtask

  task automatic wait_re(input string tag, input int bound);
    int n = 0;
    do begin
      step();
      n++;
    end while (!re_s && n < bound);
    check_eq(tag, re_s, 1'b1);
  endtask

  // Checks the 40 frame cycles following a launch cycle, then the first idle cycle.
  task automatic check_frame(input logic [7:0] b, input logic exp_next_re, input int drop_en_k,
                             input string tag);
    logic [9:0] bits;
    logic [7:0] dec;
    bits = {1'b1, b, 1'b0};
    dec  = 8'h00;
    for (int k = 0; k < 40; k++) begin
      step();
      if (k == drop_en_k) en = 1'b0;
      check_eq({tag, "_tx"}, tx_s, bits[k/4]);
      check_eq({tag, "_busy"}, busy_s, 1'b1);
      check_eq({tag, "_re"}, re_s, 1'b0);
      check_eq({tag, "_done"}, done_s, 1'b0);
      if (k >= 4 && k < 36 && (k % 4) == 2) dec[(k-4)/4] = tx_s;
    end
    check_eq({tag, "_byte"}, dec, b);
    step();
    check_eq({tag, "_done40"}, done_s, 1'b1);
    check_eq({tag, "_idle_busy"}, busy_s, 1'b0);
    check_eq({tag, "_idle_tx"}, tx_s, 1'b1);
    check_eq({tag, "_next_re"}, re_s, exp_next_re);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Reset with a byte waiting and en high: nothing may launch.
    fifo.push_back(8'hA5);
    drive_fifo();
    en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", is_busy, 1'b0);
    check_eq("rst_re", re, 1'b0);
    check_eq("rst_done", frame_done, 1'b0);
    reset = 1'b1;
    step();
    check_eq("rel_first_re", re_s, 1'b0);
    wait_re("a5_launch", 10);
    check_frame(8'hA5, 1'b0, -1, "a5");

    // Empty FIFO for 200 cycles.
    for (int i = 0; i < 200; i++) begin
      step();
      check_eq("empty_re", re_s, 1'b0);
      check_eq("empty_tx", tx_s, 1'b1);
      check_eq("empty_busy", busy_s, 1'b0);
    end

    // Back-to-back frames.
    fifo.push_back(8'h00);
    fifo.push_back(8'hFF);
    fifo.push_back(8'h55);
    drive_fifo();
    wait_re("b2b_launch", 10);
    r0 = cyc;
    check_frame(8'h00, 1'b1, -1, "b00");
    r1 = cyc;
    check_frame(8'hFF, 1'b1, -1, "bff");
    r2 = cyc;
    check_frame(8'h55, 1'b0, -1, "b55");
    check_eq("b2b_gap1", r1 - r0, 41);
    check_eq("b2b_gap2", r2 - r1, 41);

    // en dropped during bit 3 of 0x3C while another byte waits.
    fifo.push_back(8'h3C);
    fifo.push_back(8'h81);
    drive_fifo();
    wait_re("en_launch", 10);
    check_frame(8'h3C, 1'b0, 17, "e3c");
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("en_low_re", re_s, 1'b0);
      check_eq("en_low_busy", busy_s, 1'b0);
    end
    en = 1'b1;
    step();
    check_eq("en_relaunch", re_s, 1'b1);
    check_frame(8'h81, 1'b0, -1, "e81");

    // Reset during data bit 5 of 0x96; 0x5A must be the next byte sent.
    fifo.push_back(8'h96);
    fifo.push_back(8'h5A);
    drive_fifo();
    wait_re("mid_launch", 10);
    repeat (26) step();
    check_eq("mid_busy_pre", busy_s, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_tx", tx, 1'b1);
    check_eq("mid_rst_busy", is_busy, 1'b0);
    check_eq("mid_rst_re", re, 1'b0);
    check_eq("mid_rst_done", frame_done, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("mid_hold_tx", tx_s, 1'b1);
      check_eq("mid_hold_re", re_s, 1'b0);
    end
    reset = 1'b1;
    step();
    check_eq("mid_rel_first_re", re_s, 1'b0);
    wait_re("mid_relaunch", 10);
    check_frame(8'h5A, 1'b0, -1, "m5a");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
